// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants for the RISC-V pipeline
package riscv_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
endpackage

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - combinational next-PC, redirect and misalignment generation
module next_pc_gen
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             pc_a_src,
    input  logic             pc_b_src,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [WIDTH-1:0] ex_imm,
    input  logic [WIDTH-1:0] ex_rs1,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect,
    output logic             misalign
);
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] target;

    // pc_a_src=0 with pc_b_src=1 is not a redirect: the base select only matters on a jump/branch
    assign redirect = pc_a_src;
    assign base     = pc_b_src ? ex_rs1 : ex_pc;
    assign target   = (base + ex_imm) & ~WIDTH'(1);
    assign misalign = redirect & target[1];

    always_comb begin
        next_pc = pc + WIDTH'(4);
        if (redirect) begin
            next_pc = target & ~WIDTH'(3);
        end
    end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC register, next-PC select and IF/ID register
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_a_src,
    input  logic            pc_b_src,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            stall,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_valid,
    output logic            flush_id_ex,
    output logic            misalign_err
);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            redirect;
    logic            misalign;

    next_pc_gen #(.WIDTH(XLEN)) u_next_pc_gen (
        .pc       (pc),
        .pc_a_src (pc_a_src),
        .pc_b_src (pc_b_src),
        .ex_pc    (ex_pc),
        .ex_imm   (ex_imm),
        .ex_rs1   (ex_rs1),
        .next_pc  (next_pc),
        .redirect (redirect),
        .misalign (misalign)
    );

    assign imem_addr   = pc;
    assign flush_id_ex = redirect & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= XLEN'(RESET_PC);
        end else if (redirect || !stall) begin
            pc <= next_pc;
        end
    end

    // A redirect squashes the IF/ID slot even under stall: that instruction is on the wrong path
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= '0;
        end else if (!stall) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc    <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misalign) begin
            misalign_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_a_src;
    logic        pc_b_src;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush_id_ex;
    logic        misalign_err;

    int vectors    = 0;
    int miscompares = 0;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .pc_a_src     (pc_a_src),
        .pc_b_src     (pc_b_src),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .stall        (stall),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .flush_id_ex  (flush_id_ex),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_a_src = 1'b0; pc_b_src = 1'b0; stall = 1'b0;
        ex_pc = '0; ex_imm = '0; ex_rs1 = '0; imem_rdata = 32'h0050_0093;

        // reset held for two cycles
        tick(); tick();
        check("rst_addr",     imem_addr, 32'h0);
        check("rst_valid",    {31'b0, id_valid}, 32'h0);
        check("rst_instr",    id_instr, NOP);
        check("rst_id_pc",    id_pc, 32'h0);
        check("rst_misalign", {31'b0, misalign_err}, 32'h0);
        check("rst_flush",    {31'b0, flush_id_ex}, 32'h0);

        rst = 1'b0; settle();
        check("rel_addr0",  imem_addr, 32'h0);
        check("rel_valid0", {31'b0, id_valid}, 32'h0);
        tick();
        check("rel_addr4",  imem_addr, 32'h4);
        check("rel_valid1", {31'b0, id_valid}, 32'h1);
        check("rel_instr",  id_instr, 32'h0050_0093);
        check("rel_id_pc",  id_pc, 32'h0);
        tick();
        check("rel_addr8",  imem_addr, 32'h8);
        check("rel_id_pc4", id_pc, 32'h4);

        // PC-relative branch 0x10 + (-8)
        pc_a_src = 1'b1; pc_b_src = 1'b0; ex_pc = 32'h10; ex_imm = 32'hFFFF_FFF8; settle();
        check("br_flush", {31'b0, flush_id_ex}, 32'h1);
        tick();
        check("br_addr",  imem_addr, 32'h8);
        check("br_valid", {31'b0, id_valid}, 32'h0);
        check("br_instr", id_instr, NOP);
        pc_a_src = 1'b0; settle();
        check("br_flush_off", {31'b0, flush_id_ex}, 32'h0);
        tick();
        check("br_tgt_valid", {31'b0, id_valid}, 32'h1);
        check("br_tgt_id_pc", id_pc, 32'h8);
        check("br_addr_c",    imem_addr, 32'hC);

        // JALR: bit 0 dropped, then a bit-1 misaligned target
        pc_a_src = 1'b1; pc_b_src = 1'b1; ex_rs1 = 32'h101; ex_imm = 32'h4;
        tick();
        check("jalr_addr",  imem_addr, 32'h104);
        check("jalr_noerr", {31'b0, misalign_err}, 32'h0);
        ex_rs1 = 32'h102; ex_imm = 32'h0;
        tick();
        check("mis_addr", imem_addr, 32'h100);
        check("mis_err",  {31'b0, misalign_err}, 32'h1);
        pc_a_src = 1'b0; pc_b_src = 1'b0;
        tick();
        check("mis_sticky", {31'b0, misalign_err}, 32'h1);
        check("mis_id_pc",  id_pc, 32'h100);
        check("mis_addr2",  imem_addr, 32'h104);

        // three-cycle stall
        stall = 1'b1; imem_rdata = 32'h00A0_0113;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_addr", i),  imem_addr, 32'h104);
            check($sformatf("stall%0d_id_pc", i), id_pc, 32'h100);
            check($sformatf("stall%0d_instr", i), id_instr, 32'h0050_0093);
            check($sformatf("stall%0d_valid", i), {31'b0, id_valid}, 32'h1);
        end
        stall = 1'b0;
        tick();
        check("resume_addr",  imem_addr, 32'h108);
        check("resume_id_pc", id_pc, 32'h104);
        check("resume_instr", id_instr, 32'h00A0_0113);

        // stall together with redirect: redirect wins
        stall = 1'b1; pc_a_src = 1'b1; pc_b_src = 1'b0; ex_pc = 32'h200; ex_imm = 32'h20; settle();
        check("sr_flush", {31'b0, flush_id_ex}, 32'h1);
        tick();
        check("sr_addr",  imem_addr, 32'h220);
        check("sr_valid", {31'b0, id_valid}, 32'h0);
        stall = 1'b0; pc_a_src = 1'b0;

        // wrap at the top of the address space
        pc_a_src = 1'b1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
        tick();
        check("wrap_top", imem_addr, 32'hFFFF_FFFC);
        pc_a_src = 1'b0;
        tick();
        check("wrap_zero",  imem_addr, 32'h0);
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_four",  imem_addr, 32'h4);

        // reset overrides redirect and stall
        rst = 1'b1; pc_a_src = 1'b1; stall = 1'b1; settle();
        check("ovr_flush", {31'b0, flush_id_ex}, 32'h0);
        tick();
        check("ovr_addr",     imem_addr, 32'h0);
        check("ovr_valid",    {31'b0, id_valid}, 32'h0);
        check("ovr_instr",    id_instr, NOP);
        check("ovr_id_pc",    id_pc, 32'h0);
        check("ovr_misalign", {31'b0, misalign_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
